// File: rtl/period_meter_if.sv
// period_meter_if -- signal bundle between a period_meter and its user.
//   sig_in      : slow asynchronous square wave to measure
//   clear       : synchronous measurement restart (active high)
//   half_period : iclk cycles between the last two sig_in edges
//   valid       : one-cycle pulse when half_period updates
//   timeout     : level, no edge seen within TIMEOUT_CYCLES
//   sig_sync    : synchronized copy of sig_in
// master drives sig_in/clear; slave (the meter) drives the results.
interface period_meter_if #(
  parameter int WIDTH = 32
);
  logic             sig_in;
  logic             clear;
  logic [WIDTH-1:0] half_period;
  logic             valid;
  logic             timeout;
  logic             sig_sync;

  modport master (
    output sig_in, clear,
    input  half_period, valid, timeout, sig_sync
  );

  modport slave (
    input  sig_in, clear,
    output half_period, valid, timeout, sig_sync
  );
endinterface

// File: rtl/period_meter.sv
// period_meter -- measures the iclk-cycle interval between consecutive
// edges (rising or falling) of a slow asynchronous input.
//   iclk    : system clock, all state on its rising edge
//   reset_n : asynchronous active-low reset
//   pm      : period_meter_if.slave (sig_in, clear in; half_period,
//             valid, timeout, sig_sync out)
// Pipeline: s1 -> s2 -> s3/edge-evaluate (FSM stage) -> output register,
// so results appear 4 iclk edges after sig_in is first sampled.
module period_meter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic         iclk,
  input  logic         reset_n,
  period_meter_if.slave pm
);

  // Counter must hold TIMEOUT_CYCLES without wrapping.
  generate
    if (TIMEOUT_CYCLES < 1 || (longint'(TIMEOUT_CYCLES) >> WIDTH) != 0) begin : g_bad_width
      $error("period_meter: need 2**WIDTH > TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LIM = WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TIMEOUT} state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             edg;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] hp_q, hp_d, hp_o;
  logic             vld_d;
  logic [1:0]       vld_pipe;   // [0] FSM stage, [1] output register
  logic             to_q, to_d, to_o;

  // Synchronizer plus history flop; clear deliberately leaves these alone.
  always_ff @(posedge iclk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pm.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edg = s2 ^ s3;

  always_ff @(posedge iclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hp_q     <= '0;
      to_q     <= 1'b0;
      vld_pipe <= '0;
      hp_o     <= '0;
      to_o     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      hp_q     <= hp_d;
      to_q     <= to_d;
      // clear also flushes the output register so nothing already in
      // flight escapes after a restart.
      vld_pipe <= {vld_pipe[0] & ~pm.clear, vld_d};
      hp_o     <= pm.clear ? '0 : hp_q;
      to_o     <= pm.clear ? 1'b0 : to_q;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hp_d    = hp_q;
    vld_d   = 1'b0;
    to_d    = to_q;
    if (pm.clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hp_d    = '0;
      to_d    = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt_d = '0;
          if (edg) state_d = S_MEASURE;   // reference edge, nothing to report
        end
        S_MEASURE: begin
          if (edg) begin
            // Edge wins over a same-cycle limit hit: interval == TIMEOUT_CYCLES
            // is still a valid measurement.
            cnt_d = '0;
            hp_d  = cnt + WIDTH'(1);
            vld_d = 1'b1;
          end else if (cnt == LIM) begin
            state_d = S_TIMEOUT;
            cnt_d   = '0;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt + WIDTH'(1);
          end
        end
        S_TIMEOUT: begin
          cnt_d = '0;
          // The edge ending an over-long interval only restarts timing.
          if (edg) begin
            state_d = S_MEASURE;
            to_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pm.half_period = hp_o;
  assign pm.valid       = vld_pipe[1];
  assign pm.timeout     = to_o;
  assign pm.sig_sync    = s2;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter -- directed self-checking bench for period_meter
// (WIDTH=8, TIMEOUT_CYCLES=16). Inputs change 1 ns after a rising edge,
// outputs are sampled at the same point.
module tb_period_meter;

  logic iclk = 1'b0;
  logic reset_n = 1'b0;
  bit   sig = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 iclk = ~iclk;

  period_meter_if #(.WIDTH(8)) pm_if ();

  period_meter #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .iclk    (iclk),
    .reset_n (reset_n),
    .pm      (pm_if)
  );

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Toggle sig_in, then run n cycles. The edge's result is due on tick 4.
  task automatic pulse(int n, bit ev, int ehp, bit eto);
    sig = !sig;
    pm_if.sig_in = sig;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) chk("sync_old", pm_if.sig_sync, !sig);
      if (i == 2) chk("sync_new", pm_if.sig_sync, sig);
      if (i == 3) chk("valid_early", pm_if.valid, 0);
      if (i == 4) begin
        chk("valid", pm_if.valid, ev);
        chk("half_period", pm_if.half_period, ehp);
      end
      if (i == 5) chk("valid_one_cycle", pm_if.valid, 0);
      if (i >= 4) chk("timeout", pm_if.timeout, eto);
    end
  endtask

  initial begin
    pm_if.sig_in = 1'b0;
    pm_if.clear  = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_hp", pm_if.half_period, 0);
    chk("rst_valid", pm_if.valid, 0);
    chk("rst_timeout", pm_if.timeout, 0);
    chk("rst_sync", pm_if.sig_sync, 0);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // 10-cycle square wave: first edge is the reference only
    pulse(10, 0, 0, 0);
    pulse(10, 1, 10, 0);
    pulse(10, 1, 10, 0);
    pulse(10, 1, 10, 0);

    // timeout: hold 22 cycles after the reference edge
    pulse(4, 1, 10, 0);
    for (int i = 5; i <= 22; i++) begin
      tick();
      if (i == 19) chk("timeout_not_yet", pm_if.timeout, 0);
      if (i == 20) chk("timeout_set", pm_if.timeout, 1);
      if (i == 20) chk("timeout_no_valid", pm_if.valid, 0);
    end
    pulse(5, 0, 10, 0);     // leaves TIMEOUT, no measurement
    pulse(16, 1, 5, 0);     // 5-cycle interval measured
    pulse(10, 1, 16, 0);    // interval exactly at the limit

    // clear coincident with an edge
    sig = !sig;
    pm_if.sig_in = sig;
    tick(); tick();
    pm_if.clear = 1'b1;
    tick();
    pm_if.clear = 1'b0;
    chk("clr_hp", pm_if.half_period, 0);
    chk("clr_valid", pm_if.valid, 0);
    chk("clr_timeout", pm_if.timeout, 0);
    for (int i = 4; i <= 10; i++) begin
      tick();
      if (i == 4) chk("clr_valid_t4", pm_if.valid, 0);
      if (i == 4) chk("clr_hp_t4", pm_if.half_period, 0);
    end
    pulse(10, 0, 0, 0);
    pulse(10, 1, 10, 0);

    // asynchronous reset mid-interval with sig_in high
    chk("pre_rst_level", pm_if.sig_sync, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_hp", pm_if.half_period, 0);
    chk("arst_valid", pm_if.valid, 0);
    chk("arst_timeout", pm_if.timeout, 0);
    chk("arst_sync", pm_if.sig_sync, 0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk("post_rst_no_valid", pm_if.valid, 0);
      if (i == 25) chk("post_rst_timeout", pm_if.timeout, 1);
    end
    pulse(10, 0, 0, 0);
    pulse(10, 1, 10, 0);

    // sig_in toggling every cycle
    for (int i = 0; i < 12; i++) begin
      sig = !sig;
      pm_if.sig_in = sig;
      tick();
      if (i == 3) begin
        chk("n1_first_valid", pm_if.valid, 1);
        chk("n1_first_hp", pm_if.half_period, 10);
      end
      if (i >= 4) begin
        chk("n1_valid", pm_if.valid, 1);
        chk("n1_hp", pm_if.half_period, 1);
      end
    end
    for (int i = 0; i < 5; i++) tick();
    chk("n1_valid_drop", pm_if.valid, 0);
    chk("n1_hp_hold", pm_if.half_period, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the measured half-period count.
REQ-002 Parameter TIMEOUT_CYCLES, default 25000000, the largest valid edge-to-edge interval in iclk cycles; WIDTH SHALL satisfy 2**WIDTH > TIMEOUT_CYCLES (elaboration error otherwise).
REQ-003 iclk  input  1  system clock (50 MHz); all state SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sig_in  input  1  asynchronous slow square wave to be measured (e.g. a divided clock).
REQ-006 clear  input  1  synchronous measurement restart, active high.
REQ-007 half_period  output  WIDTH  iclk cycles between the last two consecutive sig_in edges.
REQ-008 valid  output  1  one-cycle pulse when half_period is updated.
REQ-009 timeout  output  1  level; high while no edge has arrived within TIMEOUT_CYCLES.
REQ-010 sig_sync  output  1  synchronized copy of sig_in.

Function
REQ-011 sig_in SHALL pass through a two-flop synchronizer (s1, s2); sig_sync = s2.
REQ-012 A third flop s3 SHALL hold the previous s2; edge = s2 XOR s3 (both rising and falling edges count).
REQ-013 Interval N = iclk cycles between consecutive cycles with edge=1; a sig_in toggling every N iclk cycles SHALL yield half_period = N.
REQ-014 Counter cnt: loaded with 0 in any cycle with edge=1, incremented otherwise while in MEASURE, held at 0 in IDLE and TIMEOUT.
REQ-015 States: IDLE (no reference edge yet), MEASURE (reference edge seen, timing interval), TIMEOUT (interval exceeded limit).
REQ-016 IDLE: edge=1 -> MEASURE, no valid pulse, half_period unchanged.
REQ-017 MEASURE, edge=1: half_period <= cnt+1, valid <= 1 in the next cycle, stay in MEASURE.
REQ-018 MEASURE, edge=0 and cnt == TIMEOUT_CYCLES-1: -> TIMEOUT, timeout <= 1.
REQ-019 Simultaneous edge=1 and cnt == TIMEOUT_CYCLES-1: edge wins, half_period = TIMEOUT_CYCLES, valid pulse, stay in MEASURE.
REQ-020 TIMEOUT: edge=1 -> MEASURE, timeout <= 0, no valid pulse (interval invalid), half_period holds last value.
REQ-021 Valid measurements SHALL lie in 1..TIMEOUT_CYCLES; cnt SHALL never wrap.
REQ-022 valid SHALL be high for exactly one cycle per accepted measurement, never two consecutive cycles unless N=1.
REQ-023 Latency: valid and new half_period SHALL appear 4 iclk rising edges after the first edge that samples the new sig_in level (s1, s2, s3/edge-evaluate, output register).
REQ-024 clear=1: next state IDLE, cnt=0, half_period=0, valid=0, timeout=0; clear SHALL take priority over a same-cycle edge or timeout; synchronizer flops unaffected.

Reset
REQ-025 reset_n low SHALL immediately force s1=s2=s3=0, cnt=0, state IDLE, half_period=0, valid=0, timeout=0, sig_sync=0.
REQ-026 Reset asserted mid-measurement SHALL discard the interval; no valid pulse SHALL follow release.
REQ-027 After release with sig_in already high, the resulting synchronizer edge SHALL be treated as the IDLE reference edge (no valid pulse).

Verification
REQ-028 Square wave toggling every 10 iclk cycles after reset -> first edge no valid; each later edge gives valid pulse with half_period=10, timeout=0.
REQ-029 TIMEOUT_CYCLES=16, sig_in held 20 cycles after reference edge -> timeout=1 exactly 16 cycles after reference edge; next edge clears timeout with no valid; following 5-cycle interval gives half_period=5.
REQ-030 TIMEOUT_CYCLES=16, interval exactly 16 -> valid, half_period=16, timeout stays 0.
REQ-031 clear pulsed in the same cycle as an edge while measuring 10-cycle period -> no valid, half_period=0, state IDLE; next edge no valid; following edge half_period=10.
REQ-032 reset_n pulsed low mid-interval with sig_in high -> all outputs 0 immediately; after release first two edges produce no valid, third edge produces correct half_period.
REQ-033 sig_in toggling every iclk cycle -> valid high continuously, half_period=1.
